// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem combinationally, queues {inst, pc} for decode.
// Latency: a word fetched in cycle N appears on inst_* in cycle N+1 when the queue was empty.
// Backpressure: inst_ready low fills the queue to DEPTH, then fetch_pc holds; redirects flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] PROG_BYTES = 32'd36
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_reg,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        fetch_done,
  output logic        fetch_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0] fetch_pc;
  logic [31:0] q_data [DEPTH];
  logic [31:0] q_pc   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic        pop;
  logic        push;
  logic        redir;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  // Head entry comes straight out of the queue registers, so imem_data never reaches inst_* in the same cycle.
  assign inst_data  = q_data[head];
  assign inst_pc    = q_pc[head];
  assign inst_pc4   = inst_pc + 32'd4;
  assign fetch_done = (fetch_pc >= PROG_BYTES) && (count == '0);

  assign pop   = inst_valid & inst_ready;
  assign redir = (redir_kind != 2'b00);
  assign push  = ((count < DEPTH_C) | pop) & (fetch_pc < PROG_BYTES) & ~redir;

  // Redirect target for the three control-transfer kinds.
  always_comb begin
    seq_pc = redir_pc + 32'd4;
    br_off = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
    target = fetch_pc;
    case (redir_kind)
      2'b01:   target = seq_pc + br_off;
      2'b10:   target = {seq_pc[31:28], redir_imm, 2'b00};
      2'b11:   target = redir_reg;
      default: target = fetch_pc;
    endcase
  end

  // Program counter and sticky misalignment flag; redirect wins over sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      fetch_err <= 1'b0;
    end else if (redir) begin
      fetch_pc <= {target[31:2], 2'b00};
      if (target[1:0] != 2'b00) begin
        fetch_err <= 1'b1;
      end
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Queue storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_data[tail] <= imem_data;
      q_pc[tail]   <= fetch_pc;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue after honouring a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redir) begin
      head  <= head + AW'(pop);
      tail  <= head + AW'(pop);
      count <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: queue-based reference model, randomized and directed stimulus.
// Expected entries are pushed when the model fetches; a negedge monitor pops on inst_valid & inst_ready.
// All waits are bounded by fixed cycle counts.
module tb_fetch_stage;

  localparam logic [31:0] PROG_BYTES = 32'd36;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] PROG [9] = '{
    32'h20010005, 32'hAC010000, 32'h2002000A, 32'h00221820, 32'h10430002,
    32'h00642020, 32'h8C050000, 32'h20040001, 32'hAC040008
  };

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc, redir_reg;
  logic [25:0] redir_imm;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, inst_pc4;
  logic        fetch_done, fetch_err;

  ent_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  bit          mon_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < PROG_BYTES) return PROG[a >> 2];
    return 32'hBAD0_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH), .PROG_BYTES(PROG_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redir_kind(redir_kind), .redir_pc(redir_pc), .redir_imm(redir_imm), .redir_reg(redir_reg),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Target computed from the architectural rules with plain integer arithmetic.
  function automatic logic [31:0] ref_target(input logic [1:0] kind, input logic [31:0] rpc,
                                             input logic [25:0] imm, input logic [31:0] rreg);
    int off;
    case (kind)
      2'b01: begin
        off = int'($signed(imm[15:0]));
        return rpc + 32'd4 + 32'(off * 4);
      end
      2'b10: return ((rpc + 32'd4) & 32'hF000_0000) | (32'(imm) * 32'd4);
      2'b11: return rreg;
      default: return m_pc;
    endcase
  endfunction

  // Monitor: state checks every cycle, scoreboard pop on each accepted head.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      ent_t e;
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_err", fetch_err, m_err);
      chk("fetch_done", fetch_done, (m_pc >= PROG_BYTES) && (exp_q.size() == 0));
      chk("inst_valid", inst_valid, exp_q.size() != 0);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("inst_data", inst_data, e.data);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_pc4", inst_pc4, e.pc + 32'd4);
        end
      end
    end
  end

  // Drive one cycle of inputs (called just after a rising edge) and advance the model at the next edge.
  task automatic cycle(input logic rdy, input logic [1:0] kind, input logic [31:0] rpc,
                       input logic [25:0] imm, input logic [31:0] rreg);
    int          sz;
    logic        do_pop, do_push;
    logic [31:0] tgt;
    inst_ready = rdy;
    redir_kind = kind;
    redir_pc   = rpc;
    redir_imm  = imm;
    redir_reg  = rreg;
    sz      = exp_q.size();
    do_pop  = (sz > 0) && rdy;
    do_push = ((sz < DEPTH) || do_pop) && (m_pc < PROG_BYTES) && (kind == 2'b00);
    tgt     = ref_target(kind, rpc, imm, rreg);
    @(posedge clk);
    #1;
    if (kind != 2'b00) begin
      exp_q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      if (tgt % 4 != 0) m_err = 1'b1;
    end else if (do_push) begin
      exp_q.push_back('{data: mem_word(m_pc), pc: m_pc});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(rdy, 2'b00, 32'h0, 26'h0, 32'h0);
  endtask

  // Assert reset, check the asynchronous return to reset values, then release.
  task automatic do_reset();
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    redir_kind = 2'b00;
    #2;
    chk("rst_inst_valid", inst_valid, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc4", inst_pc4, 32'd4);
    chk("rst_fetch_err", fetch_err, 32'd0);
    chk("rst_fetch_done", fetch_done, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    exp_q.delete();
    m_pc  = 32'h0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    inst_ready = 1'b0;
    redir_kind = 2'b00;
    redir_pc = '0;
    redir_imm = '0;
    redir_reg = '0;
    m_pc = '0;
    m_err = 1'b0;
    #1;
    do_reset();

    // Streaming from reset with decode always ready.
    idle(1'b1);
    chk("first_pc", inst_pc, 32'd0);
    chk("first_data", inst_data, 32'h20010005);
    idle(1'b1);
    chk("second_pc", inst_pc, 32'd4);
    chk("second_data", inst_data, 32'hAC010000);
    idle(1'b1);
    chk("third_pc", inst_pc, 32'd8);
    chk("third_data", inst_data, 32'h2002000A);

    // Stall: queue fills to DEPTH, head stays put.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("stall_head_pc", inst_pc, 32'd0);
    end
    chk("stall_fetch_pc", imem_addr, 32'd8);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("resume_no_gap", inst_valid, 32'd1);
    end

    // Branch forward past the program end with two entries queued.
    cycle(1'b0, 2'b01, 32'd20, 26'h0004, 32'h0);
    chk("br_target", imem_addr, 32'd40);
    chk("br_flush", inst_valid, 32'd0);
    chk("br_done", fetch_done, 32'd1);
    cycle(1'b0, 2'b01, 32'd20, 26'h0FFF9, 32'h0);
    chk("br_wrap_target", imem_addr, 32'hFFFF_FFFC);
    chk("br_wrap_done", fetch_done, 32'd1);

    // Jump out, register jump back in, then run to the program end.
    cycle(1'b0, 2'b10, 32'd24, 26'h20, 32'h0);
    chk("jmp_target", imem_addr, 32'h80);
    chk("jmp_done", fetch_done, 32'd1);
    cycle(1'b1, 2'b11, 32'h0, 26'h0, 32'd28);
    chk("jr_done_clear", fetch_done, 32'd0);
    idle(1'b1);
    chk("jr_pc", inst_pc, 32'd28);
    chk("jr_data", inst_data, 32'h20040001);
    idle(1'b1);
    chk("last_pc", inst_pc, 32'd32);
    chk("last_data", inst_data, 32'hAC040008);
    idle(1'b1);
    chk("end_done", fetch_done, 32'd1);
    idle(1'b1);

    // Restart and reset mid-stream.
    cycle(1'b1, 2'b11, 32'h0, 26'h0, 32'd0);
    repeat (3) idle(1'b1);
    do_reset();

    // Misaligned register jump: sticky error, aligned fetch address.
    cycle(1'b1, 2'b11, 32'h0, 26'h0, 32'h0000_000E);
    chk("mis_err", fetch_err, 32'd1);
    chk("mis_addr", imem_addr, 32'h0C);
    for (int i = 0; i < 10; i++) idle(1'($urandom_range(0, 1)));
    chk("mis_err_sticky", fetch_err, 32'd1);
    do_reset();

    // Randomized traffic: random backpressure and redirects of every kind.
    for (int i = 0; i < 600; i++) begin
      int          r;
      int          off;
      logic        rdy;
      logic [15:0] i16;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 6) begin
        off = int'($urandom_range(0, 12)) - 6;
        i16 = 16'(off);
        cycle(rdy, 2'b01, 32'($urandom_range(0, 8)) * 32'd4, {10'h0, i16}, 32'h0);
      end else if (r < 10) begin
        cycle(rdy, 2'b10, 32'($urandom_range(0, 8)) * 32'd4, 26'($urandom_range(0, 10)), 32'h0);
      end else if (r < 15) begin
        cycle(rdy, 2'b11, 32'h0, 26'h0,
              32'($urandom_range(0, 10)) * 32'd4 + (($urandom_range(0, 19) == 0) ? 32'd1 : 32'd0));
      end else begin
        idle(rdy);
      end
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
